l2_arbiter_fsm: RTL

- Registered, stateful arbiter that shares the single L2 cache port between the IF (instruction) L1 cache and the MEM (data) L1 cache.
- Grant is held for the full duration of a transaction until L2 responds.
- Round-robin on contention, so neither L1 starves.
- A watchdog flags an L2 transaction that never completes.

---
 rtl/lc3b_types.sv | 16 +
 rtl/l2_arbiter_fsm.sv | 128 ++++++++++++
 2 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/burst types and L2 arbiter state encoding
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [255:0] lc3b_burst;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT_I,
        ARB_GRANT_D
    } lc3b_arb_state;

    // Value of last_grant meaning "MEM was served last".
    localparam logic lc3b_arb_pri_d = 1'b1;

endpackage

// File: rtl/l2_arbiter_fsm.sv
// rtl/l2_arbiter_fsm.sv - round-robin IF/MEM arbiter for the shared L2 port with transaction watchdog
module l2_arbiter_fsm
    import lc3b_types::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic      clk,
    input  logic      rst_n,
    input  lc3b_word  IF_address,
    input  logic      IF_read,
    input  logic      IF_write,
    input  lc3b_burst IF_wdata,
    input  lc3b_word  MEM_address,
    input  logic      MEM_read,
    input  logic      MEM_write,
    input  lc3b_burst MEM_wdata,
    input  logic      l2_resp,
    input  lc3b_burst l2_rdata,
    output logic      l2i_resp,
    output lc3b_burst l2i_rdata,
    output logic      l2d_resp,
    output lc3b_burst l2d_rdata,
    output lc3b_word  l2_address,
    output logic      l2_read,
    output logic      l2_write,
    output lc3b_burst l2_wdata,
    output logic      gnt_i,
    output logic      gnt_d,
    output logic      timeout_err
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

    lc3b_arb_state state;
    logic          last_grant;
    logic [CW-1:0] wd_cnt;
    logic          req_i;
    logic          req_d;

    assign req_i = IF_read | IF_write;
    assign req_d = MEM_read | MEM_write;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= ~lc3b_arb_pri_d;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (req_i && req_d)
                        state <= (last_grant == lc3b_arb_pri_d) ? ARB_GRANT_I : ARB_GRANT_D;
                    else if (req_i)
                        state <= ARB_GRANT_I;
                    else if (req_d)
                        state <= ARB_GRANT_D;
                end
                ARB_GRANT_I: begin
                    if (l2_resp) begin
                        state      <= ARB_IDLE;
                        last_grant <= ~lc3b_arb_pri_d;
                    end else if (!req_i) begin
                        state <= ARB_IDLE;
                    end
                end
                ARB_GRANT_D: begin
                    if (l2_resp) begin
                        state      <= ARB_IDLE;
                        last_grant <= lc3b_arb_pri_d;
                    end else if (!req_d) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Error sets on the same edge the counter reaches TMAX; the FSM is never forced out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == ARB_IDLE || l2_resp) begin
            wd_cnt <= '0;
        end else if (TIMEOUT_CYCLES != 0) begin
            if (wd_cnt != TMAX)
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == TMAX - CW'(1) || wd_cnt == TMAX)
                timeout_err <= 1'b1;
        end
    end

    always_comb begin
        l2i_resp   = 1'b0;
        l2i_rdata  = '0;
        l2d_resp   = 1'b0;
        l2d_rdata  = '0;
        l2_address = '0;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_wdata   = '0;
        gnt_i      = 1'b0;
        gnt_d      = 1'b0;
        case (state)
            ARB_GRANT_I: begin
                l2_address = IF_address;
                l2_read    = IF_read;
                l2_write   = IF_write;
                l2_wdata   = IF_wdata;
                l2i_resp   = l2_resp;
                l2i_rdata  = l2_rdata;
                gnt_i      = 1'b1;
            end
            ARB_GRANT_D: begin
                l2_address = MEM_address;
                l2_read    = MEM_read;
                l2_write   = MEM_write;
                l2_wdata   = MEM_wdata;
                l2d_resp   = l2_resp;
                l2d_rdata  = l2_rdata;
                gnt_d      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
